// File: rtl/set_bit_serializer.sv
// Walks a W-bit word (optionally inverted) and emits the index of each set
// bit, lowest first, one valid/ready beat per set bit; an all-zero word yields one empty beat.
module set_bit_serializer #(
  parameter int W  = 32,
  parameter int IW = (W > 1) ? $clog2(W) : 1,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  input  logic [W-1:0]  in_x,
  input  logic          in_inv,
  output logic          in_rdy,
  output logic          out_vld,
  output logic [IW-1:0] out_idx,
  output logic [CW-1:0] out_pos,
  output logic          out_last,
  output logic          out_empty,
  input  logic          out_rdy,
  output logic          busy
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  pending, pending_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic [W-1:0]  pending_clr;
  logic [IW-1:0] low_idx;
  logic          found;
  logic          is_empty;
  logic          is_single;
  logic          emit;
  logic          xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      cnt     <= cnt_nxt;
    end
  end

  // Priority encoder: first set bit scanning upward wins.
  always_comb begin
    low_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (pending[i] && !found) begin
        low_idx = IW'(i);
        found   = 1'b1;
      end
    end
  end

  assign pending_clr = pending & (pending - 1'b1);
  assign is_empty    = (pending == '0);
  assign is_single   = (pending_clr == '0);
  assign emit        = (state == EMIT);
  assign xfer        = emit && out_rdy;

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    cnt_nxt     = cnt;
    case (state)
      IDLE: begin
        if (in_vld) begin
          pending_nxt = in_x ^ {W{in_inv}};
          cnt_nxt     = '0;
          state_nxt   = EMIT;
        end
      end
      EMIT: begin
        if (xfer) begin
          pending_nxt = pending_clr;
          cnt_nxt     = cnt + 1'b1;
          if (is_single) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs come only from registered state; gated to zero while idle.
  assign in_rdy    = !emit;
  assign out_vld   = emit;
  assign busy      = emit;
  assign out_idx   = emit ? low_idx : '0;
  assign out_pos   = emit ? cnt : '0;
  assign out_empty = emit && is_empty;
  assign out_last  = emit && is_single;

endmodule

// File: tb/tb_set_bit_serializer.sv
// Directed bench for set_bit_serializer at W=8; inputs change and outputs are
// sampled on the falling clock edge.
module tb_set_bit_serializer;

  localparam int W  = 8;
  localparam int IW = 3;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_vld;
  logic [W-1:0]  in_x;
  logic          in_inv;
  logic          in_rdy;
  logic          out_vld;
  logic [IW-1:0] out_idx;
  logic [CW-1:0] out_pos;
  logic          out_last;
  logic          out_empty;
  logic          out_rdy;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  set_bit_serializer #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_vld    (in_vld),
    .in_x      (in_x),
    .in_inv    (in_inv),
    .in_rdy    (in_rdy),
    .out_vld   (out_vld),
    .out_idx   (out_idx),
    .out_pos   (out_pos),
    .out_last  (out_last),
    .out_empty (out_empty),
    .out_rdy   (out_rdy),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge in IDLE; returns on the falling edge after accept.
  task automatic present(input logic [W-1:0] x, input logic inv);
    in_vld = 1'b1;
    in_x   = x;
    in_inv = inv;
    @(negedge clk);
    in_vld = 1'b0;
    in_inv = ~inv;
  endtask

  // Checks the beat shown now, then advances one cycle.
  task automatic beat(input string tag, input int idx, input int pos,
                      input logic last, input logic empty);
    check({tag, ".vld"},   32'(out_vld),   32'd1);
    check({tag, ".busy"},  32'(busy),      32'd1);
    check({tag, ".rdy"},   32'(in_rdy),    32'd0);
    check({tag, ".idx"},   32'(out_idx),   32'(idx));
    check({tag, ".pos"},   32'(out_pos),   32'(pos));
    check({tag, ".last"},  32'(out_last),  32'(last));
    check({tag, ".empty"}, 32'(out_empty), 32'(empty));
    @(negedge clk);
  endtask

  task automatic idle_chk(input string tag);
    check({tag, ".in_rdy"},  32'(in_rdy),  32'd1);
    check({tag, ".out_vld"}, 32'(out_vld), 32'd0);
    check({tag, ".busy"},    32'(busy),    32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    in_vld  = 1'b0;
    in_x    = '0;
    in_inv  = 1'b0;
    out_rdy = 1'b1;
    @(negedge clk);
    check("rst.out_vld", 32'(out_vld),   32'd0);
    check("rst.last",    32'(out_last),  32'd0);
    check("rst.empty",   32'(out_empty), 32'd0);
    check("rst.idx",     32'(out_idx),   32'd0);
    check("rst.pos",     32'(out_pos),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    idle_chk("rst_rel");

    // all-zero word: one empty beat
    present(8'h00, 1'b0);
    beat("zero", 0, 0, 1'b1, 1'b1);
    idle_chk("zero.after");

    // 1010_0100 -> 2,5,7
    present(8'b1010_0100, 1'b0);
    beat("a4.b0", 2, 0, 1'b0, 1'b0);
    beat("a4.b1", 5, 1, 1'b0, 1'b0);
    beat("a4.b2", 7, 2, 1'b1, 1'b0);
    idle_chk("a4.after");

    // inverted words
    present(8'hFF, 1'b1);
    beat("invff", 0, 0, 1'b1, 1'b1);
    idle_chk("invff.after");
    present(8'b1111_1110, 1'b1);
    beat("invfe", 0, 0, 1'b1, 1'b0);
    idle_chk("invfe.after");

    // backpressure holds the first beat of 0x81
    out_rdy = 1'b0;
    present(8'h81, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bp.vld",  32'(out_vld),  32'd1);
      check("bp.idx",  32'(out_idx),  32'd0);
      check("bp.pos",  32'(out_pos),  32'd0);
      check("bp.last", 32'(out_last), 32'd0);
      @(negedge clk);
    end
    out_rdy = 1'b1;
    beat("bp.b0", 0, 0, 1'b0, 1'b0);
    beat("bp.b1", 7, 1, 1'b1, 1'b0);
    idle_chk("bp.after");

    // asynchronous reset in the middle of 0xFF
    present(8'hFF, 1'b0);
    beat("mid.b0", 0, 0, 1'b0, 1'b0);
    beat("mid.b1", 1, 1, 1'b0, 1'b0);
    beat("mid.b2", 2, 2, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("mid.async_vld",  32'(out_vld),  32'd0);
    check("mid.async_busy", 32'(busy),     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_chk("mid.after");
    end

    // in_vld held: A=0x03 then B=0x10 offered during EMIT
    in_vld = 1'b1;
    in_x   = 8'h03;
    in_inv = 1'b0;
    @(negedge clk);
    in_x = 8'h10;
    beat("hold.a0", 0, 0, 1'b0, 1'b0);
    beat("hold.a1", 1, 1, 1'b1, 1'b0);
    idle_chk("hold.gap");
    @(negedge clk);
    in_vld = 1'b0;
    beat("hold.b0", 4, 0, 1'b1, 1'b0);
    idle_chk("hold.after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/set_bit_serializer.md
Name: set_bit_serializer

Overview:
- Sequential companion to the population classifier: takes one W-bit word per transaction, optionally inverted, and emits the index of every set bit, lowest first, one per beat.
- Both ports use valid/ready handshakes.
- Used where a multi-hot vector, such as a grant mask or a pending-request mask, is walked one entry per cycle.
- An all-zero word produces exactly one beat, flagged empty.

Parameters:
W, 32, input word width (W >= 1)
IW, (W > 1) ? $clog2(W) : 1, index width (derived; not overridden)
CW, $clog2(W+1), beat-ordinal width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_vld  in  1  input word valid
in_x  in  W  input word
in_inv  in  1  when 1, word is inverted before processing (serialize clear bits)
in_rdy  out  1  block can accept a word
out_vld  out  1  output beat valid
out_idx  out  IW  bit index of current beat
out_pos  out  CW  0-based ordinal of current beat within the word
out_last  out  1  final beat of the word
out_empty  out  1  conditioned word had no set bits (single beat)
out_rdy  in  1  downstream accepts beat
busy  out  1  word in progress (= out_vld)

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset values:
  - State IDLE; pending register 0; beat counter 0.
  - out_vld, busy, out_last and out_empty are 0; out_idx and out_pos are 0.
  - in_rdy is 1 after reset deasserts.
  - Assertion clears outputs immediately, without waiting for clk.
- States:
  - IDLE: in_rdy=1, out_vld=0.
  - EMIT: in_rdy=0, out_vld=1.
- Accept:
  - In IDLE with in_vld=1, register pending = in_x ^ {W{in_inv}} and reset the counter to 0.
  - Next state is EMIT.
  - in_vld in EMIT is ignored; the upstream must hold it.
- Latency: first out_vld in the cycle after acceptance.
- Beat contents in EMIT, all combinational from registered state:
  - out_idx = index of lowest set bit of pending, or 0 if pending==0.
  - out_pos = beat counter.
  - out_empty = (pending == 0).
  - out_last = out_empty OR pending has exactly one bit set, i.e. (pending & (pending-1)) == 0.
- Beat transfer (out_vld & out_rdy):
  - pending <= pending & (pending - 1); counter += 1.
  - If out_last, go to IDLE.
- Backpressure: while out_vld=1 and out_rdy=0, out_idx, out_pos, out_last and out_empty hold stable. There is no combinational path from out_rdy to any output.
- Throughput: a word with N>0 set bits takes N beats plus 1 IDLE cycle before the next accept. An empty word takes 1 beat plus 1 IDLE cycle.
- Counter: never exceeds W-1 on a valid beat. CW bits suffice; no wrap.
- W=1: out_idx is 1 bit and always 0. The word is either empty (1 beat, out_empty=1) or one beat idx 0 with last=1, empty=0.
- Reset mid-operation: the in-flight word is discarded, no residual beats appear, and the block returns to IDLE.
- in_inv: sampled only at accept and ignored otherwise.

Test Plan:
- W=8, in_x=8'h00, in_inv=0, out_rdy=1 -> one beat: out_empty=1, out_last=1, out_idx=0, out_pos=0. in_rdy=1 in the following cycle.
- W=8, in_x=8'b1010_0100, in_inv=0, out_rdy=1:
  - Three consecutive beats: out_idx 2,5,7; out_pos 0,1,2; out_last only on the third.
  - in_rdy is low during the 3 beat cycles and high the cycle after.
- W=8, in_inv=1:
  - in_x=8'hFF -> single empty beat.
  - in_x=8'b1111_1110 -> single beat out_idx=0, out_last=1, out_empty=0.
- W=8, in_x=8'h81, out_rdy held low 3 cycles after out_vld:
  - out_idx=0, out_pos=0, out_last=0 stable all 3 cycles.
  - After out_rdy=1: beat idx 0, then idx 7 with last=1.
- W=8, in_x=8'hFF, rst_n pulsed low after 3 transferred beats:
  - out_vld drops before the next clk edge.
  - After release, in_rdy=1 and no beats appear until a new word is accepted.
- W=8, in_vld held high, word A=8'h03 then B=8'h10 presented:
  - A produces beats idx 0,1.
  - B is accepted only in the IDLE cycle after A's last beat and produces idx 4.
  - B presented during EMIT has no effect.
